// File: rtl/uart_pkg.sv
// Shared definitions for the thread->UART write path.
//  - Arbiter and byte-slot state encodings.
//  - UART 8N1 frame constants (frame length, start and stop bit levels).
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_DRAIN   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } slot_state_t;

  localparam int   UART_FRAME_BITS = 10;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first.
// Ports:
//  clock  in   system clock
//  reset  in   synchronous, active-high; aborts any frame, line returns high
//  load   in   take data when busy is low
//  data   in   byte to send
//  tx     out  serial line (registered), idles high
//  busy   out  high while a frame is in flight; drops on the final stop-bit
//              cycle so that a byte loaded then starts with no idle gap
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  // Remaining data bits plus stop bit; bit 0 is the next bit to go out.
  logic [8:0]        shift_r;
  logic [BAUD_W-1:0] baud_r;
  logic [3:0]        bit_r;
  logic              active_r;
  logic              busy_r;
  logic              tx_r;

  // Frame sequencer: start bit on load, then shift one bit every CLKS_PER_BIT cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_r  <= 9'h1FF;
      baud_r   <= '0;
      bit_r    <= 4'd0;
      active_r <= 1'b0;
      busy_r   <= 1'b0;
      tx_r     <= STOP_BIT;
    end else if (load && !busy_r) begin
      shift_r  <= {STOP_BIT, data};
      baud_r   <= '0;
      bit_r    <= 4'd0;
      active_r <= 1'b1;
      busy_r   <= 1'b1;
      tx_r     <= START_BIT;
    end else if (active_r) begin
      if (baud_r == BAUD_LAST) begin
        baud_r <= '0;
        if (bit_r == BIT_LAST) begin
          active_r <= 1'b0;
          busy_r   <= 1'b0;
          tx_r     <= STOP_BIT;
        end else begin
          bit_r   <= bit_r + 4'd1;
          tx_r    <= shift_r[0];
          shift_r <= {STOP_BIT, shift_r[8:1]};
        end
      end else begin
        baud_r <= baud_r + BAUD_W'(1);
        // Open the load window one cycle early: the last stop-bit cycle.
        if (bit_r == BIT_LAST && baud_r == BAUD_PRE) begin
          busy_r <= 1'b0;
        end else begin
          busy_r <= busy_r;
        end
      end
    end else begin
      tx_r <= STOP_BIT;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;

endmodule

// File: rtl/uart_write_arbiter.sv
// Thread->UART write responder: round-robin write lock, single-cycle ready/valid
// byte slot for the lock holder, one-byte holding register, 8N1 serialiser.
// Ports:
//  clock, reset        system clock, synchronous active-high reset
//  write_lock_req[N]   per-thread lock request (level)
//  write_lock_res[N]   per-thread grant, one-hot or zero
//  write_ready[N]      one-cycle byte-slot pulse to the holder only
//  write_data[8N]      per-thread byte, thread i on [8i+7:8i]
//  write_data_valid[N] per-thread byte valid, sampled the cycle after write_ready
//  uart_tx             serial line, idles high
//  tx_busy             serialiser shifting or holding register full
module uart_write_arbiter
  import uart_pkg::*;
#(
  parameter int NTHREADS     = 2,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NTHREADS-1:0]   write_lock_req,
  output logic [NTHREADS-1:0]   write_lock_res,
  output logic [NTHREADS-1:0]   write_ready,
  input  logic [8*NTHREADS-1:0] write_data,
  input  logic [NTHREADS-1:0]   write_data_valid,
  output logic                  uart_tx,
  output logic                  tx_busy
);

  localparam int GW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

  // First requester at or after ptr, wrapping.
  function automatic logic [GW-1:0] pick_next(input logic [NTHREADS-1:0] req,
                                              input logic [GW-1:0]       ptr);
    logic [GW-1:0] sel;
    logic [GW-1:0] idx;
    logic          found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NTHREADS; k++) begin
      idx = GW'((int'(ptr) + k) % NTHREADS);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [NTHREADS-1:0] onehot(input logic [GW-1:0] idx);
    logic [NTHREADS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  arb_state_t          arb_state_r, arb_next_s;
  slot_state_t         slot_r, slot_next_s;
  logic [GW-1:0]       grant_idx_r, grant_next_s;
  logic [GW-1:0]       rr_ptr_r, rr_next_s;
  logic [NTHREADS-1:0] res_r, res_next_s;
  logic [NTHREADS-1:0] ready_r, ready_next_s;
  logic [7:0]          hold_data_r;
  logic                hold_full_r;
  logic                latch_s;
  logic                load_s;
  logic                ser_busy_s;
  logic                ser_tx_s;
  logic                req_g_s;
  logic                valid_g_s;
  logic [7:0]          data_g_s;

  // Holder's request, valid and byte, muxed by the current grant.
  assign req_g_s   = write_lock_req[grant_idx_r];
  assign valid_g_s = write_data_valid[grant_idx_r];
  assign data_g_s  = write_data[{grant_idx_r, 3'b000} +: 8];

  assign tx_busy = hold_full_r | ser_busy_s;
  assign load_s  = hold_full_r & ~ser_busy_s;

  // Round-robin lock arbitration; a new grant waits for the line to drain.
  always_comb begin
    arb_next_s   = arb_state_r;
    grant_next_s = grant_idx_r;
    rr_next_s    = rr_ptr_r;
    res_next_s   = res_r;
    case (arb_state_r)
      ARB_IDLE: begin
        if ((|write_lock_req) && !tx_busy) begin
          grant_next_s = pick_next(write_lock_req, rr_ptr_r);
          res_next_s   = onehot(grant_next_s);
          arb_next_s   = ARB_GRANTED;
        end else begin
          res_next_s = '0;
        end
      end
      ARB_GRANTED: begin
        if (!req_g_s) begin
          res_next_s = '0;
          rr_next_s  = GW'((int'(grant_idx_r) + 1) % NTHREADS);
          arb_next_s = ARB_DRAIN;
        end else begin
          res_next_s = onehot(grant_idx_r);
        end
      end
      ARB_DRAIN: begin
        res_next_s = '0;
        if (!tx_busy) begin
          arb_next_s = ARB_IDLE;
        end else begin
          arb_next_s = ARB_DRAIN;
        end
      end
      default: begin
        res_next_s = '0;
        arb_next_s = ARB_IDLE;
      end
    endcase
  end

  // Byte slot for the holder: pulse ready, sample valid the next cycle, repeat.
  always_comb begin
    slot_next_s = slot_r;
    latch_s     = 1'b0;
    if (arb_state_r != ARB_GRANTED || !req_g_s) begin
      slot_next_s = S_OFF;
    end else begin
      case (slot_r)
        S_OFF: begin
          if (!hold_full_r) begin
            slot_next_s = S_PULSE;
          end else begin
            slot_next_s = S_OFF;
          end
        end
        S_PULSE: slot_next_s = S_WAIT;
        S_WAIT: begin
          // With or without data the slot closes; an empty pulse just re-arms.
          latch_s     = valid_g_s;
          slot_next_s = S_OFF;
        end
        default: slot_next_s = S_OFF;
      endcase
    end
    if (slot_next_s == S_PULSE) begin
      ready_next_s = onehot(grant_idx_r);
    end else begin
      ready_next_s = '0;
    end
  end

  // Arbiter, slot and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      arb_state_r <= ARB_IDLE;
      slot_r      <= S_OFF;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      res_r       <= '0;
      ready_r     <= '0;
    end else begin
      arb_state_r <= arb_next_s;
      slot_r      <= slot_next_s;
      grant_idx_r <= grant_next_s;
      rr_ptr_r    <= rr_next_s;
      res_r       <= res_next_s;
      ready_r     <= ready_next_s;
    end
  end

  // One-byte holding register between the slot and the serialiser.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full_r <= 1'b0;
      hold_data_r <= 8'h00;
    end else if (latch_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= data_g_s;
    end else if (load_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock(clock),
    .reset(reset),
    .load (load_s),
    .data (hold_data_r),
    .tx   (ser_tx_s),
    .busy (ser_busy_s)
  );

  assign write_lock_res = res_r;
  assign write_ready    = ready_r;
  assign uart_tx        = ser_tx_s;

endmodule
